// File: rtl/bf_norm_div_if.sv
// Handshake bundle for bf_norm_div.
// Purpose : carries the tap stream in and the normalized pixel out.
// Signals : in_valid/in_ready/prod/wgt  (tap side)
//           out_valid/out_ready/out_pix (pixel side)
// Modports: slave  - the divider block
//           master - the producer/consumer driving it (e.g. a testbench)
interface bf_norm_div_if;
    localparam int unsigned PROD_W = 22;
    localparam int unsigned WGT_W  = 14;
    localparam int unsigned PIX_W  = 8;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] prod;
    logic [WGT_W-1:0]  wgt;
    logic              out_valid;
    logic              out_ready;
    logic [PIX_W-1:0]  out_pix;

    modport slave  (input  in_valid, prod, wgt, out_ready,
                    output in_ready, out_valid, out_pix);
    modport master (output in_valid, prod, wgt, out_ready,
                    input  in_ready, out_valid, out_pix);
endinterface

// File: rtl/bf_norm_div.sv
// Bilateral-filter normalizer: accumulates TAPS weighted products and weights,
// then divides sum(prod) by sum(wgt) with an 8-step restoring divider.
// Ports : clk, rst_n (async, active-low), bus (bf_norm_div_if.slave)
// Params: TAPS  - taps per output pixel
//         CNT_W - tap counter width (TAPS <= 2**CNT_W)
// Config: define BF_ROUND_EN to round half-up (dividend = num + den/2);
//         otherwise the quotient is truncated. Latency is identical.
module bf_norm_div #(
    parameter int unsigned TAPS  = 121,
    parameter int unsigned CNT_W = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    bf_norm_div_if.slave  bus
);
    localparam int unsigned PROD_W = 22;
    localparam int unsigned WGT_W  = 14;
    localparam int unsigned NUM_W  = 29;
    localparam int unsigned DEN_W  = 21;
    localparam int unsigned REM_W  = 30;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned STEP_W = 4;

    typedef enum logic [1:0] {ST_ACC, ST_DIV, ST_OUT} state_t;

    state_t             state_q, state_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [DEN_W-1:0]   den_q, den_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [PIX_W-1:0]   quo_q, quo_d;
    logic               zero_q, zero_d;
    logic               sat_q, sat_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [PIX_W-1:0]   out_pix_q, out_pix_d;

    logic [REM_W-1:0]   dividend_c;
    logic [REM_W-1:0]   den_sh_c;
    logic [2:0]         bit_c;

    // Dividend seen by the divider when it is loaded.
    always_comb begin
`ifdef BF_ROUND_EN
        dividend_c = REM_W'(num_q) + REM_W'(den_q >> 1);
`else
        dividend_c = REM_W'(num_q);
`endif
    end

    // DIV step 0 loads the divider; steps 1..8 resolve quotient bits 7..0.
    always_comb begin
        bit_c    = 3'(STEP_W'(8) - step_q);
        den_sh_c = REM_W'(den_q) << bit_c;
    end

    // Next-state and datapath.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        den_d       = den_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        zero_d      = zero_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;

        case (state_q)
            ST_ACC: begin
                if (bus.in_valid && in_ready_q) begin
                    num_d = num_q + NUM_W'(bus.prod);
                    den_d = den_q + DEN_W'(bus.wgt);
                    if (cnt_q == CNT_W'(TAPS - 1)) begin
                        cnt_d   = '0;
                        step_d  = '0;
                        state_d = ST_DIV;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DIV: begin
                step_d = step_q + STEP_W'(1);
                if (step_q == '0) begin
                    // Load; a quotient of 256 or more cannot fit in 8 bits.
                    rem_d  = dividend_c;
                    quo_d  = '0;
                    zero_d = (den_q == '0);
                    sat_d  = (den_q != '0) && (dividend_c >= (REM_W'(den_q) << 8));
                end else begin
                    if (rem_q >= den_sh_c) begin
                        rem_d        = rem_q - den_sh_c;
                        quo_d[bit_c] = 1'b1;
                    end
                    if (step_q == STEP_W'(8)) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        out_pix_d   = zero_q ? '0 : (sat_q ? '1 : quo_d);
                    end
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d     = ST_ACC;
                    out_valid_d = 1'b0;
                    num_d       = '0;
                    den_d       = '0;
                    cnt_d       = '0;
                end
            end
            default: state_d = ST_ACC;
        endcase

        in_ready_d = (state_d == ST_ACC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            num_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            step_q      <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            zero_q      <= 1'b0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            den_q       <= den_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            zero_q      <= zero_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pix   = out_pix_q;
endmodule

// File: tb/tb_bf_norm_div.sv
// Directed testbench for bf_norm_div: window arithmetic, rounding build,
// zero weights, saturation, back-pressure, mid-window/mid-divide reset and
// gapped input handshakes.
module tb_bf_norm_div;
    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    bf_norm_div_if bus ();

    bf_norm_div #(.TAPS(121), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one tap and wait for it to be accepted; optional idle gap first.
    task automatic send_tap(input logic [21:0] p, input logic [13:0] w, input bit gaps);
        bit acc;
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.prod     = 22'($urandom);
                bus.wgt      = 14'($urandom);
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.prod     = p;
        bus.wgt      = w;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            vectors++; errors++;
            $display("FAIL tap_accept: in_ready never seen, required 1");
        end
    endtask

    // Count cycles from the current (post-accept) point until out_valid.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.prod      = '0;
        bus.wgt       = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic take_out();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.prod = '0; bus.wgt = '0;
        rst_n = 1'b0;
        #12;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_pix !== 8'd0) begin
            errors++;
            $display("FAIL reset_out: out_valid=%b out_pix=%0d, required 0/0", bus.out_valid, bus.out_pix);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_uniform();
        int n;
        for (int i = 0; i < 121; i++) send_tap(22'd5000, 14'd100, 1'b0);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL uniform_div_entry: in_ready=%b out_valid=%b, required 0/0", bus.in_ready, bus.out_valid);
        end
        wait_out(n);
        vectors++;
        if (n !== 9) begin
            errors++;
            $display("FAIL uniform_latency: got %0d cycles, required 9", n);
        end
        vectors++;
        if (bus.out_pix !== 8'd50) begin
            errors++;
            $display("FAIL uniform_pix: got %0d, required 50", bus.out_pix);
        end
        take_out();
    endtask

    task automatic test_round();
        int n;
        logic [7:0] exp_pix;
`ifdef BF_ROUND_EN
        exp_pix = 8'd3;
`else
        exp_pix = 8'd2;
`endif
        send_tap(22'd2, 14'd1, 1'b0);
        send_tap(22'd3, 14'd1, 1'b0);
        for (int i = 0; i < 119; i++) send_tap(22'd0, 14'd0, 1'b0);
        wait_out(n);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_pix !== exp_pix) begin
            errors++;
            $display("FAIL round_pix: valid=%b pix=%0d, required 1/%0d", bus.out_valid, bus.out_pix, exp_pix);
        end
        take_out();
    endtask

    task automatic test_zero_wgt();
        int n;
        for (int i = 0; i < 121; i++) send_tap(22'd0, 14'd0, 1'b0);
        wait_out(n);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_pix !== 8'd0 || n !== 9) begin
            errors++;
            $display("FAIL zero_wgt: valid=%b pix=%0d lat=%0d, required 1/0/9", bus.out_valid, bus.out_pix, n);
        end
        take_out();
    endtask

    task automatic test_saturate();
        int n;
        send_tap(22'd1000, 14'd1, 1'b0);
        for (int i = 0; i < 120; i++) send_tap(22'd0, 14'd0, 1'b0);
        wait_out(n);
        vectors++;
        if (bus.out_pix !== 8'd255) begin
            errors++;
            $display("FAIL saturate_pix: got %0d, required 255", bus.out_pix);
        end
        take_out();
    endtask

    // Stalled consumer with taps offered meanwhile; they must not be consumed.
    task automatic test_backpressure();
        int n;
        for (int i = 0; i < 121; i++) send_tap(22'd200, 14'd2, 1'b0);
        wait_out(n);
        bus.in_valid = 1'b1; bus.prod = 22'h3FFFFF; bus.wgt = 14'd1;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_pix !== 8'd100 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c%0d: valid=%b pix=%0d in_ready=%b, required 1/100/0",
                         c, bus.out_valid, bus.out_pix, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        take_out();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pix !== 8'd100) begin
            errors++;
            $display("FAIL stall_release: valid=%b in_ready=%b pix=%0d, required 0/1/100",
                     bus.out_valid, bus.in_ready, bus.out_pix);
        end
        for (int i = 0; i < 121; i++) send_tap(22'd7, 14'd1, 1'b0);
        wait_out(n);
        vectors++;
        if (bus.out_pix !== 8'd7 || n !== 9) begin
            errors++;
            $display("FAIL stall_next_window: pix=%0d lat=%0d, required 7/9", bus.out_pix, n);
        end
        take_out();
    endtask

    task automatic test_reset_mid_acc();
        int n;
        bit seen;
        for (int i = 0; i < 60; i++) send_tap(22'd9000, 14'd3, 1'b0);
        do_reset();
        for (int i = 0; i < 121; i++) send_tap(22'd7, 14'd1, 1'b0);
        wait_out(n);
        vectors++;
        if (bus.out_pix !== 8'd7 || n !== 9) begin
            errors++;
            $display("FAIL reset_mid_acc_pix: pix=%0d lat=%0d, required 7/9", bus.out_pix, n);
        end
        take_out();
        seen = 1'b0;
        repeat (15) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_acc_single: extra out_valid seen=%b, required 0", seen);
        end
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        for (int i = 0; i < 121; i++) send_tap(22'd5000, 14'd100, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        seen = 1'b0;
        repeat (15) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_pix !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_div: seen=%b in_ready=%b pix=%0d, required 0/1/0",
                     seen, bus.in_ready, bus.out_pix);
        end
    endtask

    task automatic test_gapped_valid();
        int n;
        for (int i = 0; i < 121; i++) send_tap(22'd600, 14'd3, 1'b1);
        wait_out(n);
        vectors++;
        if (bus.out_pix !== 8'd200 || n !== 9) begin
            errors++;
            $display("FAIL gapped_pix: pix=%0d lat=%0d, required 200/9", bus.out_pix, n);
        end
        take_out();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_uniform();
        test_round();
        test_zero_wgt();
        test_saturate();
        test_backpressure();
        test_reset_mid_acc();
        test_reset_mid_div();
        test_gapped_valid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bf_norm_div.md
BF_NORM_DIV -- requirements
Module: bf_norm_div

Interface
REQ-001 SHALL have parameter TAPS, default 121, meaning weighted taps per output pixel (11x11 window).
REQ-002 SHALL have parameter CNT_W, default 7, meaning tap counter width; TAPS SHALL be at most 2^CNT_W.
REQ-003 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have in_valid, input, 1, tap present on prod/wgt.
REQ-006 SHALL have in_ready, output, 1, block accepts a tap this cycle.
REQ-007 SHALL have prod, input, 22, unsigned weight*intensity product from the multiply stage.
REQ-008 SHALL have wgt, input, 14, unsigned weight matching prod.
REQ-009 SHALL have out_valid, output, 1, normalized pixel available.
REQ-010 SHALL have out_ready, input, 1, consumer takes the pixel.
REQ-011 SHALL have out_pix, output, 8, normalized filtered pixel.

Function
REQ-012 SHALL implement FSM states ACC, DIV and OUT.
REQ-013 In ACC, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-014 A tap SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-015 On each accepted tap: num += prod (29-bit unsigned), den += wgt (21-bit unsigned), cnt += 1; no overflow is possible at TAPS=121.
REQ-016 When the TAPS-th tap is accepted: ACC->DIV, cnt=0, and the divider is loaded with the final num/den, including that tap.
REQ-017 DIV SHALL run a restoring division for exactly 8 cycles, resolving one quotient bit per cycle, MSB first.
REQ-017a Each DIV cycle: for bit k, if rem >= (den<<k), set q[k] and subtract.
REQ-018 After the 8th DIV cycle: DIV->OUT, out_valid=1, out_pix=q; latency is 9 cycles from the last-tap accept edge to out_valid high.
REQ-019 If den==0 at load, q SHALL be forced to 0.
REQ-020 If the quotient exceeds 255, out_pix SHALL saturate to 255.
REQ-021 In OUT, out_valid and out_pix SHALL hold stable until out_ready=1.
REQ-022 On the out_ready handshake: OUT->ACC, out_valid=0, num/den/cnt cleared, and in_ready=1 on the next cycle.
REQ-023 in_valid, prod and wgt SHALL be ignored outside ACC; taps presented then are not consumed.
REQ-024 out_pix SHALL retain its last value while out_valid=0.

Reset
REQ-025 While rst_n=0: state=ACC, num=0, den=0, cnt=0, quotient/remainder=0, out_valid=0, out_pix=0.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.
REQ-027 Reset asserted mid-ACC, mid-DIV or in OUT SHALL discard all partial results; no pixel is emitted for the interrupted window.

Configuration
REQ-028 Macro BF_ROUND_EN defined: the divider is loaded with num + (den>>1), giving round-half-up.
REQ-029 Macro BF_ROUND_EN undefined: the divider is loaded with num, giving truncation; interface and latency are identical in both builds.

Verification
REQ-030 121 taps of wgt=100, prod=5000 with in_valid held high -> out_valid exactly 9 cycles after the last accept, out_pix=50.
REQ-031 Tap0 wgt=1 prod=2, tap1 wgt=1 prod=3, 119 zero taps -> out_pix=2 without BF_ROUND_EN, 3 with it.
REQ-032 121 taps of wgt=0, prod=0 -> out_pix=0, out_valid=1, no X on outputs.
REQ-033 Complete window, then out_ready held low 5 cycles -> out_valid and out_pix stable and in_ready=0 throughout; on handshake in_ready=1 the next cycle.
REQ-034 60 taps accepted, rst_n pulsed low, then 121 taps of wgt=1 prod=7 -> single output, out_pix=7.
REQ-035 in_valid toggled randomly across 121 taps of wgt=3 prod=600 -> out_pix=200; cnt advances only on handshake cycles.
